// File: rtl/uart_bus_bridge_if.sv
// Byte-stream and CPU peripheral bus signals of the serial bus bridge.
// The master modport is the bridge side; the slave modport is the UART/bus side.
`timescale 1ns/1ps
interface uart_bus_bridge_if;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUS_WE;
  logic        BUS_RE;
  logic [31:0] BUS_A;
  logic [31:0] BUS_WD;
  logic [31:0] BUS_RD;

  modport master (
    input  RX_DATA, RX_VALID, TX_READY, BUS_RD,
    output TX_DATA, TX_VALID, BUS_WE, BUS_RE, BUS_A, BUS_WD
  );

  modport slave (
    output RX_DATA, RX_VALID, TX_READY, BUS_RD,
    input  TX_DATA, TX_VALID, BUS_WE, BUS_RE, BUS_A, BUS_WD
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// Serial-side bus initiator: decodes 'W'/'R' byte frames into single word bus
// accesses and returns the acknowledge or read data as bytes.
`timescale 1ns/1ps
module uart_bus_bridge #(
  parameter int unsigned      CNT_W   = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = 24'd5000000
) (
  input  logic                CLK,
  input  logic                RESET,
  uart_bus_bridge_if.master   bus,
  output logic                BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_RD_CAP, S_SEND
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             is_wr;
  logic [31:0]      shreg;
  logic [2:0]       left;

  assign BUSY = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      is_wr        <= 1'b0;
      shreg        <= '0;
      left         <= '0;
      bus.TX_DATA  <= '0;
      bus.TX_VALID <= 1'b0;
      bus.BUS_WE   <= 1'b0;
      bus.BUS_RE   <= 1'b0;
      bus.BUS_A    <= '0;
      bus.BUS_WD   <= '0;
    end else begin
      bus.BUS_WE <= 1'b0;
      bus.BUS_RE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.RX_VALID) begin
            if (bus.RX_DATA == CMD_WR || bus.RX_DATA == CMD_RD) begin
              is_wr <= (bus.RX_DATA == CMD_WR);
              idx   <= '0;
              cnt   <= '0;
              state <= S_ADDR;
            end else begin
              shreg        <= {24'h000000, RSP_ERR};
              left         <= 3'd1;
              bus.TX_DATA  <= RSP_ERR;
              bus.TX_VALID <= 1'b1;
              state        <= S_SEND;
            end
          end
        end
        // A byte in the expiry cycle wins over the abort.
        S_ADDR: begin
          if (bus.RX_VALID) begin
            bus.BUS_A[{idx, 3'b000} +: 8] <= bus.RX_DATA;
            cnt <= '0;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (is_wr) begin
                state <= S_DATA;
              end else begin
                bus.BUS_RE <= 1'b1;
                state      <= S_BUS_RD;
              end
            end
          end else if (cnt == TIMEOUT) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bus.RX_VALID) begin
            bus.BUS_WD[{idx, 3'b000} +: 8] <= bus.RX_DATA;
            cnt <= '0;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              bus.BUS_WE <= 1'b1;
              state      <= S_BUS_WR;
            end
          end else if (cnt == TIMEOUT) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BUS_WR: begin
          shreg        <= {24'h000000, RSP_ACK};
          left         <= 3'd1;
          bus.TX_DATA  <= RSP_ACK;
          bus.TX_VALID <= 1'b1;
          state        <= S_SEND;
        end
        S_BUS_RD: begin
          state <= S_RD_CAP;
        end
        S_RD_CAP: begin
          shreg        <= bus.BUS_RD;
          left         <= 3'd4;
          bus.TX_DATA  <= bus.BUS_RD[7:0];
          bus.TX_VALID <= 1'b1;
          state        <= S_SEND;
        end
        S_SEND: begin
          if (bus.TX_READY) begin
            shreg       <= {8'h00, shreg[31:8]};
            left        <= left - 3'd1;
            bus.TX_DATA <= shreg[15:8];
            if (left == 3'd1) begin
              bus.TX_VALID <= 1'b0;
              state        <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed self-checking bench for uart_bus_bridge with a one-cycle-latency bus model.
`timescale 1ns/1ps
module tb_uart_bus_bridge;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic BUSY;

  uart_bus_bridge_if b();

  uart_bus_bridge #(.CNT_W(24), .TIMEOUT(24'd16)) dut (
    .CLK(CLK), .RESET(RESET), .bus(b.master), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Observation of the DUT, sampled mid-cycle on the falling edge.
  int we_cnt = 0, re_cnt = 0, both_err = 0, stab_err = 0;
  int last_rx_cyc = 0, we_cyc = 0, re_cyc = 0, txv_cyc = 0;
  logic [31:0] we_a = '0, we_wd = '0, re_a = '0;
  logic prev_valid = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] tx_q[$];

  always @(negedge CLK) begin
    if (b.RX_VALID) last_rx_cyc = cyc;
    if (b.BUS_WE) begin we_cnt++; we_cyc = cyc; we_a = b.BUS_A; we_wd = b.BUS_WD; end
    if (b.BUS_RE) begin re_cnt++; re_cyc = cyc; re_a = b.BUS_A; end
    if (b.BUS_WE && b.BUS_RE) both_err++;
    if (b.TX_VALID && !prev_valid) txv_cyc = cyc;
    if (prev_hold && (!b.TX_VALID || b.TX_DATA !== prev_data)) stab_err++;
    if (b.TX_VALID && b.TX_READY) tx_q.push_back(b.TX_DATA);
    prev_valid = b.TX_VALID;
    prev_hold  = b.TX_VALID && !b.TX_READY;
    prev_data  = b.TX_DATA;
  end

  // Bus read data is only meaningful in the cycle after BUS_RE.
  logic re_seen = 1'b0;
  logic [31:0] rd_val = '0;
  always @(negedge CLK) re_seen = b.BUS_RE;
  always @(posedge CLK) begin
    #1;
    b.BUS_RD = re_seen ? rd_val : 32'hA5A5A5A5;
  end

  int ready_mode = 0;
  always @(posedge CLK) begin
    #1;
    b.TX_READY = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [7:0] get_tx(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] v);
    b.RX_DATA  = v;
    b.RX_VALID = 1'b1;
    @(posedge CLK); #1;
    b.RX_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (BUSY !== 1'b0 && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    ok = (BUSY === 1'b0);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if ({b.TX_DATA, b.TX_VALID, b.BUS_WE, b.BUS_RE, BUSY} !== 12'h000) begin
      failures++; $display("FAIL reset_ctrl: got data=%h v=%b we=%b re=%b busy=%b required all 0",
                           b.TX_DATA, b.TX_VALID, b.BUS_WE, b.BUS_RE, BUSY); end
    checks++; if (b.BUS_A !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h required 0", b.BUS_A); end
    checks++; if (b.BUS_WD !== 32'h0) begin failures++; $display("FAIL reset_wd: got %h required 0", b.BUS_WD); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_write();
    int we0 = we_cnt, re0 = re_cnt, q0 = tx_q.size();
    bit ok;
    logic [7:0] frame [9] = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (frame[i]) send_byte(frame[i]);
    wait_idle(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wr_idle: BUSY=%b required 0", BUSY); end
    checks++; if (we_cnt - we0 !== 1 || re_cnt - re0 !== 0) begin failures++;
      $display("FAIL wr_strobes: got we=%0d re=%0d required we=1 re=0", we_cnt - we0, re_cnt - re0); end
    checks++; if (we_a !== 32'h00000010) begin failures++; $display("FAIL wr_addr: got %h required 00000010", we_a); end
    checks++; if (we_wd !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data: got %h required deadbeef", we_wd); end
    checks++; if (tx_q.size() - q0 !== 1 || get_tx(q0) !== 8'h4B) begin failures++;
      $display("FAIL wr_resp: got %0d bytes first=%h required 1 byte 4b", tx_q.size() - q0, get_tx(q0)); end
    checks++; if (we_cyc - last_rx_cyc !== 1 || txv_cyc - we_cyc !== 1) begin failures++;
      $display("FAIL wr_latency: got rx->we=%0d we->tx=%0d required 1 1", we_cyc - last_rx_cyc, txv_cyc - we_cyc); end
  endtask

  task automatic test_read();
    int we0 = we_cnt, re0 = re_cnt, q0 = tx_q.size();
    bit ok;
    logic [31:0] got;
    logic [7:0] frame [5] = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
    rd_val = 32'h12345678;
    foreach (frame[i]) send_byte(frame[i]);
    wait_idle(30, ok);
    got = {get_tx(q0 + 3), get_tx(q0 + 2), get_tx(q0 + 1), get_tx(q0)};
    checks++; if (!ok) begin failures++; $display("FAIL rd_idle: BUSY=%b required 0", BUSY); end
    checks++; if (re_cnt - re0 !== 1 || we_cnt - we0 !== 0) begin failures++;
      $display("FAIL rd_strobes: got re=%0d we=%0d required re=1 we=0", re_cnt - re0, we_cnt - we0); end
    checks++; if (re_a !== 32'h00000008) begin failures++; $display("FAIL rd_addr: got %h required 00000008", re_a); end
    checks++; if (tx_q.size() - q0 !== 4 || got !== 32'h12345678) begin failures++;
      $display("FAIL rd_bytes: got %0d bytes value %h required 4 bytes 12345678", tx_q.size() - q0, got); end
    checks++; if (re_cyc - last_rx_cyc !== 1 || txv_cyc - re_cyc !== 2) begin failures++;
      $display("FAIL rd_latency: got rx->re=%0d re->tx=%0d required 1 2", re_cyc - last_rx_cyc, txv_cyc - re_cyc); end
  endtask

  task automatic test_read_backpressure();
    int re0 = re_cnt, q0 = tx_q.size(), s0 = stab_err;
    bit ok;
    logic [31:0] got;
    logic [7:0] frame [5] = '{8'h52, 8'h11, 8'h22, 8'h33, 8'h44};
    rd_val = 32'hCAFEF00D;
    ready_mode = 1;
    foreach (frame[i]) send_byte(frame[i]);
    wait_idle(300, ok);
    ready_mode = 0;
    got = {get_tx(q0 + 3), get_tx(q0 + 2), get_tx(q0 + 1), get_tx(q0)};
    checks++; if (!ok) begin failures++; $display("FAIL bp_idle: BUSY=%b required 0", BUSY); end
    checks++; if (re_cnt - re0 !== 1 || re_a !== 32'h44332211) begin failures++;
      $display("FAIL bp_read: got re=%0d addr=%h required 1 44332211", re_cnt - re0, re_a); end
    checks++; if (tx_q.size() - q0 !== 4 || got !== 32'hCAFEF00D) begin failures++;
      $display("FAIL bp_bytes: got %0d bytes value %h required 4 bytes cafef00d", tx_q.size() - q0, got); end
    checks++; if (stab_err - s0 !== 0) begin failures++;
      $display("FAIL bp_stable: got %0d hold violations required 0", stab_err - s0); end
  endtask

  task automatic test_bad_cmd();
    int we0 = we_cnt, re0 = re_cnt, q0 = tx_q.size();
    bit ok;
    logic [31:0] got;
    logic [7:0] frame [5] = '{8'h52, 8'h20, 8'h00, 8'h00, 8'h00};
    send_byte(8'h41);
    wait_idle(20, ok);
    checks++; if (!ok || tx_q.size() - q0 !== 1 || get_tx(q0) !== 8'h3F) begin failures++;
      $display("FAIL bad_resp: got idle=%b %0d bytes first=%h required 1 byte 3f", ok, tx_q.size() - q0, get_tx(q0)); end
    checks++; if (we_cnt - we0 !== 0 || re_cnt - re0 !== 0) begin failures++;
      $display("FAIL bad_strobes: got we=%0d re=%0d required 0 0", we_cnt - we0, re_cnt - re0); end
    q0 = tx_q.size();
    rd_val = 32'hA1B2C3D4;
    foreach (frame[i]) send_byte(frame[i]);
    wait_idle(30, ok);
    got = {get_tx(q0 + 3), get_tx(q0 + 2), get_tx(q0 + 1), get_tx(q0)};
    checks++; if (!ok || re_a !== 32'h00000020 || got !== 32'hA1B2C3D4) begin failures++;
      $display("FAIL bad_follow_read: got idle=%b addr=%h data=%h required 1 00000020 a1b2c3d4", ok, re_a, got); end
  endtask

  task automatic test_timeout();
    int we0 = we_cnt, re0 = re_cnt, q0 = tx_q.size();
    bit ok;
    logic [31:0] got;
    logic [7:0] wr [9] = '{8'h57, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
    logic [7:0] ad [4] = '{8'h0C, 8'h00, 8'h00, 8'h00};
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h02);
    repeat (16) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL to_not_early: BUSY=%b required 1 at count 16", BUSY); end
    @(posedge CLK); #1;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL to_abort: BUSY=%b required 0", BUSY); end
    repeat (5) @(posedge CLK);
    #1;
    checks++; if (we_cnt - we0 !== 0 || re_cnt - re0 !== 0 || tx_q.size() - q0 !== 0) begin failures++;
      $display("FAIL to_silent: got we=%0d re=%0d tx=%0d required 0 0 0", we_cnt - we0, re_cnt - re0, tx_q.size() - q0); end
    foreach (wr[i]) send_byte(wr[i]);
    wait_idle(30, ok);
    checks++; if (!ok || we_cnt - we0 !== 1 || we_a !== 32'h01020304 || we_wd !== 32'h05060708
                  || get_tx(q0) !== 8'h4B) begin failures++;
      $display("FAIL to_next_write: got idle=%b we=%0d addr=%h wd=%h rsp=%h required 1 1 01020304 05060708 4b",
               ok, we_cnt - we0, we_a, we_wd, get_tx(q0)); end
    q0 = tx_q.size();
    rd_val = 32'h0F1E2D3C;
    send_byte(8'h52);
    foreach (ad[i]) begin
      repeat (16) @(posedge CLK);
      #1;
      send_byte(ad[i]);
    end
    wait_idle(30, ok);
    got = {get_tx(q0 + 3), get_tx(q0 + 2), get_tx(q0 + 1), get_tx(q0)};
    checks++; if (!ok || re_cnt - re0 !== 1 || re_a !== 32'h0000000C || got !== 32'h0F1E2D3C) begin failures++;
      $display("FAIL to_boundary_read: got idle=%b re=%0d addr=%h data=%h required 1 1 0000000c 0f1e2d3c",
               ok, re_cnt - re0, re_a, got); end
  endtask

  task automatic test_reset_mid_send();
    int we0 = we_cnt, re0 = re_cnt, q0 = tx_q.size(), n = 0;
    bit ok;
    logic [7:0] rd [5] = '{8'h52, 8'h30, 8'h00, 8'h00, 8'h00};
    logic [7:0] wr [9] = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    rd_val = 32'h55667788;
    foreach (rd[i]) send_byte(rd[i]);
    while (tx_q.size() < q0 + 2 && n < 50) begin @(posedge CLK); #1; n++; end
    checks++; if (tx_q.size() - q0 !== 2 || b.TX_VALID !== 1'b1 || b.TX_DATA !== 8'h66) begin failures++;
      $display("FAIL mid_pre: got %0d bytes valid=%b data=%h required 2 1 66", tx_q.size() - q0, b.TX_VALID, b.TX_DATA); end
    #2;
    RESET = 1'b0;
    #1;
    checks++; if ({b.TX_DATA, b.TX_VALID, b.BUS_WE, b.BUS_RE, BUSY} !== 12'h000
                  || b.BUS_A !== 32'h0 || b.BUS_WD !== 32'h0) begin failures++;
      $display("FAIL mid_async: got data=%h v=%b we=%b re=%b busy=%b a=%h wd=%h required all 0",
               b.TX_DATA, b.TX_VALID, b.BUS_WE, b.BUS_RE, BUSY, b.BUS_A, b.BUS_WD); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    checks++; if (tx_q.size() - q0 !== 2 || re_cnt - re0 !== 1 || we_cnt - we0 !== 0 || BUSY !== 1'b0) begin failures++;
      $display("FAIL mid_discard: got tx=%0d re=%0d we=%0d busy=%b required 2 1 0 0",
               tx_q.size() - q0, re_cnt - re0, we_cnt - we0, BUSY); end
    q0 = tx_q.size();
    foreach (wr[i]) send_byte(wr[i]);
    wait_idle(30, ok);
    checks++; if (!ok || we_cnt - we0 !== 1 || we_a !== 32'h00000040 || we_wd !== 32'h11223344
                  || tx_q.size() - q0 !== 1 || get_tx(q0) !== 8'h4B) begin failures++;
      $display("FAIL mid_new_frame: got idle=%b we=%0d addr=%h wd=%h tx=%0d rsp=%h required 1 1 00000040 11223344 1 4b",
               ok, we_cnt - we0, we_a, we_wd, tx_q.size() - q0, get_tx(q0)); end
    checks++; if (both_err !== 0) begin failures++;
      $display("FAIL strobe_exclusive: got %0d cycles with WE and RE high required 0", both_err); end
  endtask

  initial begin
    b.RX_DATA  = 8'h00;
    b.RX_VALID = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_read_backpressure();
    test_bad_cmd();
    test_timeout();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
